// File: rtl/note_pkg.sv
// +--------------------------------------------------------------------------+
// | note_pkg                                                                 |
// | Shared types and constants for the note_scroller block.                  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package note_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Chart ROM word encoding: bit 0 = red, bit 1 = blue, both set = end.
    localparam logic [1:0] c_note_empty = 2'b00;
    localparam logic [1:0] c_note_red   = 2'b01;
    localparam logic [1:0] c_note_blue  = 2'b10;
    localparam logic [1:0] c_note_end   = 2'b11;

    localparam int NUM_SLOTS      = 10;
    localparam int CELL_W_DEFAULT = 7;

endpackage

`default_nettype wire

// File: rtl/chart_prefetch.sv
// +--------------------------------------------------------------------------+
// | chart_prefetch                                                           |
// | Chart ROM address generator and one-entry prefetch of the next cell.     |
// | Optional: NOTE_SCROLLER_LOOP_EN rewinds to address 0 at end of chart.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module chart_prefetch
    import note_pkg::*;
#(
    parameter int CHART_AW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_load,
    input  logic                i_consume,
    input  logic                i_refill_en,
    input  logic [1:0]          i_chart_data,
    output logic [CHART_AW-1:0] o_chart_addr,
    output logic [1:0]          o_nxt,
    output logic                o_nxt_valid,
    output logic                o_end_hit
);

    localparam logic [CHART_AW-1:0] c_addr_one = {{(CHART_AW-1){1'b0}}, 1'b1};

    logic [CHART_AW-1:0] r_addr;
    logic [1:0]          r_nxt;
    logic                r_nxt_valid;
    logic                r_chart_end;
    logic                r_want;
    logic                w_read;
    logic                w_is_end;

    // A refill is only requested the cycle after a shift, so the address has
    // been stable for at least one cycle and the ROM word is valid.
    assign w_read    = i_load | (r_want & i_refill_en);
    assign w_is_end  = (i_chart_data == c_note_end) | (&r_addr);
    assign o_end_hit = w_read & w_is_end;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_addr      <= '0;
            r_nxt       <= c_note_empty;
            r_nxt_valid <= 1'b0;
            r_chart_end <= 1'b0;
            r_want      <= 1'b0;
        end else if (w_read) begin
            r_want      <= 1'b0;
            r_nxt_valid <= 1'b1;
            if (w_is_end) begin
                r_nxt <= c_note_empty;
`ifdef NOTE_SCROLLER_LOOP_EN
                r_addr <= '0;
`else
                r_chart_end <= 1'b1;
`endif
            end else begin
                r_nxt  <= i_chart_data;
                r_addr <= r_addr + c_addr_one;
            end
        end else if (i_consume && !r_chart_end) begin
            r_nxt_valid <= 1'b0;
            r_want      <= 1'b1;
        end
    end

    assign o_chart_addr = r_addr;
    assign o_nxt        = r_nxt;
    assign o_nxt_valid  = r_nxt_valid;

endmodule

`default_nettype wire

// File: rtl/note_scroller.sv
// +--------------------------------------------------------------------------+
// | note_scroller                                                            |
// | Rhythm-game note highway: playback FSM and red/blue lane shift registers.|
// | Optional: NOTE_SCROLLER_LOOP_EN loops the chart instead of draining.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module note_scroller
    import note_pkg::*;
#(
    parameter int CHART_AW = 8,
    parameter int CELL_W   = CELL_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 step_tick,
    output logic [CHART_AW-1:0]  chart_addr,
    input  logic [1:0]           chart_data,
    output logic [NUM_SLOTS-1:0] red_notes,
    output logic [NUM_SLOTS-1:0] blue_notes,
    output logic [2:0]           offset,
    output logic                 playing,
    output logic                 done,
    output logic                 red_at_target,
    output logic                 blue_at_target
);

    localparam logic [2:0] c_offset_last = 3'(CELL_W - 1);

    state_t               r_state;
    logic [NUM_SLOTS-1:0] r_red;
    logic [NUM_SLOTS-1:0] r_blue;
    logic [2:0]           r_offset;
    logic                 r_playing;
    logic                 r_done;

    logic [1:0]           w_nxt;
    logic                 w_nxt_valid;
    logic                 w_end_hit;
    logic                 w_start_ok;
    logic                 w_active;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_shift;
    logic                 w_lanes_empty;

    assign w_start_ok    = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_active      = (r_state == S_PLAY) | (r_state == S_DRAIN);
    assign w_tick        = w_active & step_tick & ~pause;
    assign w_boundary    = (r_offset == c_offset_last);
    assign w_shift       = w_tick & w_boundary & w_nxt_valid;
    assign w_lanes_empty = ~(|r_red) & ~(|r_blue);

    chart_prefetch #(
        .CHART_AW(CHART_AW)
    ) u_prefetch (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok),
        .i_load      (r_state == S_LOAD),
        .i_consume   (w_shift),
        .i_refill_en (r_state == S_PLAY),
        .i_chart_data(chart_data),
        .o_chart_addr(chart_addr),
        .o_nxt       (w_nxt),
        .o_nxt_valid (w_nxt_valid),
        .o_end_hit   (w_end_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_red     <= '0;
            r_blue    <= '0;
            r_offset  <= '0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_state  <= S_FETCH;
                        r_red    <= '0;
                        r_blue   <= '0;
                        r_offset <= '0;
                        r_done   <= 1'b0;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_playing <= 1'b1;
`ifdef NOTE_SCROLLER_LOOP_EN
                    r_state <= S_PLAY;
`else
                    r_state <= w_end_hit ? S_DRAIN : S_PLAY;
`endif
                end
                S_PLAY, S_DRAIN: begin
                    if (w_tick && !w_boundary) begin
                        r_offset <= r_offset + 3'd1;
                    end else if (w_shift) begin
                        r_offset <= '0;
                        r_red    <= {r_red[NUM_SLOTS-2:0], w_nxt[0]};
                        r_blue   <= {r_blue[NUM_SLOTS-2:0], w_nxt[1]};
                        // Lanes already clear at a boundary: the last note has left.
                        if (r_state == S_DRAIN && w_lanes_empty) begin
                            r_state   <= S_DONE;
                            r_playing <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
`ifndef NOTE_SCROLLER_LOOP_EN
                    if (r_state == S_PLAY && w_end_hit) begin
                        r_state <= S_DRAIN;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign red_notes      = r_red;
    assign blue_notes     = r_blue;
    assign offset         = r_offset;
    assign playing        = r_playing;
    assign done           = r_done;
    assign red_at_target  = r_red[NUM_SLOTS-1];
    assign blue_at_target = r_blue[NUM_SLOTS-1];

endmodule

`default_nettype wire

// File: tb/tb_note_scroller.sv
// +--------------------------------------------------------------------------+
// | tb_note_scroller                                                         |
// | Directed self-checking bench for note_scroller (CELL_W=7, 8-bit chart).  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_note_scroller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic       step_tick;
    logic [7:0] chart_addr;
    logic [1:0] chart_data;
    logic [9:0] red_notes;
    logic [9:0] blue_notes;
    logic [2:0] offset;
    logic       playing;
    logic       done;
    logic       red_at_target;
    logic       blue_at_target;

    logic [1:0] rom [256];
    int         n_vec = 0;
    int         n_err = 0;

    note_scroller #(
        .CHART_AW(8),
        .CELL_W  (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pause         (pause),
        .step_tick     (step_tick),
        .chart_addr    (chart_addr),
        .chart_data    (chart_data),
        .red_notes     (red_notes),
        .blue_notes    (blue_notes),
        .offset        (offset),
        .playing       (playing),
        .done          (done),
        .red_at_target (red_at_target),
        .blue_at_target(blue_at_target)
    );

    always #5 clk = ~clk;

    // Registered ROM: word appears one cycle after its address.
    always @(posedge clk) chart_data <= rom[chart_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scroll step every 4 cycles; returns on a falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) step_tick = 1'b1;
            @(negedge clk) step_tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; step_tick = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_red", red_notes, 10'd0);
        chk("rst_blue", blue_notes, 10'd0);
        chk("rst_offset", offset, 3'd0);
        chk("rst_addr", chart_addr, 8'd0);
        chk("rst_playing", playing, 1'b0);
        chk("rst_done", done, 1'b0);

`ifdef NOTE_SCROLLER_LOOP_EN
        rom[0] = 2'b01; rom[1] = 2'b11;
        do_start();
        tick(28);
        chk("loop_red_4", red_notes, 10'b0000001010);
        chk("loop_done_4", done, 1'b0);
        tick(42);
        chk("loop_red_10", red_notes, 10'b1010101010);
        chk("loop_tgt_10", red_at_target, 1'b1);
        tick(7);
        chk("loop_red_11", red_notes, 10'b0101010101);
        chk("loop_playing", playing, 1'b1);
        chk("loop_done_11", done, 1'b0);
`else
        rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b00; rom[3] = 2'b11;
        tick(1);
        chk("idle_tick_offset", offset, 3'd0);
        do_start();
        chk("play_playing", playing, 1'b1);
        chk("play_addr", chart_addr, 8'd1);
        tick(3);
        chk("offset_3", offset, 3'd3);

        pause = 1'b1;
        tick(20);
        chk("pause_offset", offset, 3'd3);
        chk("pause_red", red_notes, 10'd0);
        chk("pause_addr", chart_addr, 8'd1);
        pause = 1'b0;

        tick(4);
        chk("t7_red", red_notes, 10'b0000000001);
        chk("t7_blue", blue_notes, 10'd0);
        chk("t7_offset", offset, 3'd0);
        chk("t7_addr", chart_addr, 8'd2);
        tick(7);
        chk("t14_red", red_notes, 10'b0000000010);
        chk("t14_blue", blue_notes, 10'b0000000001);
        tick(7);
        chk("t21_red", red_notes, 10'b0000000100);
        chk("t21_blue", blue_notes, 10'b0000000010);
        chk("t21_playing", playing, 1'b1);
        tick(49);
        chk("t70_red", red_notes, 10'b1000000000);
        chk("t70_blue", blue_notes, 10'b0100000000);
        chk("t70_red_tgt", red_at_target, 1'b1);
        tick(7);
        chk("t77_red_tgt", red_at_target, 1'b0);
        chk("t77_blue_tgt", blue_at_target, 1'b1);
        tick(13);
        chk("t90_red", red_notes, 10'd0);
        chk("t90_blue", blue_notes, 10'd0);
        chk("t90_offset", offset, 3'd6);
        chk("t90_done", done, 1'b0);
        tick(1);
        chk("t91_done", done, 1'b1);
        chk("t91_playing", playing, 1'b0);
        chk("t91_offset", offset, 3'd0);
        chk("drain_addr", chart_addr, 8'd3);
        tick(1);
        chk("done_tick_offset", offset, 3'd0);

        // Restart from DONE, reset with notes in flight, restart.
        do_start();
        chk("restart_addr", chart_addr, 8'd1);
        tick(10);
        chk("flight_red", red_notes, 10'b0000000001);
        chk("flight_offset", offset, 3'd3);
        do_reset();
        chk("mid_rst_red", red_notes, 10'd0);
        chk("mid_rst_offset", offset, 3'd0);
        chk("mid_rst_addr", chart_addr, 8'd0);
        chk("mid_rst_playing", playing, 1'b0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("refetch_addr0", chart_addr, 8'd0);
        repeat (2) @(negedge clk);
        chk("refetch_addr1", chart_addr, 8'd1);

        // Back-to-back ticks over an alternating chart.
        do_reset();
        rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b01;
        rom[3] = 2'b10; rom[4] = 2'b01; rom[5] = 2'b11;
        do_start();
        @(negedge clk) step_tick = 1'b1;
        repeat (35) @(negedge clk);
        step_tick = 1'b0;
        chk("b2b_red", red_notes, 10'b0000010101);
        chk("b2b_blue", blue_notes, 10'b0000001010);
        chk("b2b_offset", offset, 3'd0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_start_playing", playing, 1'b1);
        chk("busy_start_red", red_notes, 10'b0000010101);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 Parameter CHART_AW, default 8, chart address width.
REQ-002 Parameter CELL_W, default 7, offset steps per note cell; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin playback; honoured only in IDLE or DONE.
REQ-006 pause  input  1  level; while high, step_tick is ignored.
REQ-007 step_tick  input  1  one-cycle scroll-step strobe.
REQ-008 chart_addr  output  CHART_AW  chart ROM read address.
REQ-009 chart_data  input  2  ROM word, valid 1 cycle after chart_addr. Codes: 00 empty, 01 red, 10 blue, 11 end-of-chart.
REQ-010 red_notes  output  10  red occupancy per cell slot; slot 0 is the entry slot.
REQ-011 blue_notes  output  10  blue occupancy per cell slot.
REQ-012 offset  output  3  sub-cell scroll position, range 0..CELL_W-1.
REQ-013 playing  output  1  high in PLAY and DRAIN.
REQ-014 done  output  1  high in DONE.
REQ-015 red_at_target and blue_at_target  outputs  1 each  equal red_notes[9] and blue_notes[9].

Function
REQ-016 States: IDLE, FETCH, LOAD, PLAY, DRAIN, DONE.
REQ-017 IDLE/DONE + start: go to FETCH; chart_addr=0; lanes and offset cleared.
REQ-018 FETCH always goes to LOAD on the next cycle.
REQ-019 LOAD: capture chart_data into prefetch register nxt; set nxt_valid; increment chart_addr; go to PLAY. If the code is 11, set chart_end, store nxt as 00, and go to DRAIN.
REQ-020 PLAY/DRAIN, step_tick & !pause, offset<CELL_W-1: increment offset.
REQ-021 PLAY/DRAIN, step_tick & !pause, offset==CELL_W-1, nxt_valid: offset=0; both lanes shift up one slot (slot 9 discarded); slot 0 loads from nxt (red=nxt[0], blue=nxt[1]); clear nxt_valid.
REQ-022 Boundary tick with nxt_valid low: ignore the tick (stall); offset and lanes hold.
REQ-023 In PLAY, the cycle after a boundary shift reads chart_data into nxt at the current address, then increments the address. Chart latency is therefore hidden when ticks are at least 2 cycles apart.
REQ-024 End code 11 read in PLAY: set chart_end; nxt=00 with nxt_valid=1; go to DRAIN. Stop issuing reads.
REQ-025 DRAIN: nxt is held at 00 and valid; the state goes to DONE once both lanes are all zero at a cell boundary.
REQ-026 When chart_addr reaches 2^CHART_AW-1 and that word is read, treat it as end-of-chart even if its code is not 11.
REQ-027 A cell never holds both red and blue; code 11 never enters the lanes.
REQ-028 start outside IDLE/DONE, and step_tick in IDLE, FETCH, LOAD or DONE, are ignored.

Reset
REQ-029 rst has priority over all other inputs and is valid mid-operation. Resulting values: state IDLE; red_notes=0; blue_notes=0; offset=0; chart_addr=0; nxt=00; nxt_valid=0; chart_end=0; playing=0; done=0.

Configuration
REQ-030 With NOTE_SCROLLER_LOOP_EN defined, end-of-chart instead resets chart_addr to 0 and refetches; the block stays in PLAY and never enters DRAIN or DONE. Without the macro, REQ-024 to REQ-026 apply.

Structure
REQ-031 Shared package note_pkg holds the state enum, the note codes (EMPTY/RED/BLUE/END), NUM_SLOTS=10, and the default CELL_W=7.
REQ-032 One sub-module, chart_prefetch, owns chart_addr, nxt, nxt_valid and chart_end. The FSM and the lane shift registers stay in note_scroller.

Verification
REQ-033 Chart {01,10,00,11}, CELL_W=7, tick every 4 cycles. After 7 ticks red_notes=0000000001. After 14 ticks red=0000000010 and blue=0000000001.
REQ-034 Same chart run to completion: done asserts after the last note leaves slot 9; total boundary shifts are 3+10=13, with no reads after the 11 word.
REQ-035 pause held for 20 ticks mid-PLAY: offset, lanes and chart_addr are unchanged; resume continues from the same offset.
REQ-036 Ticks on consecutive cycles: no note is lost or duplicated. Boundary ticks arriving while nxt_valid=0 are stalled, with offset held at CELL_W-1.
REQ-037 rst asserted in PLAY with notes in flight: on the next cycle all outputs are 0 and the state is IDLE. A subsequent start re-reads address 0.
REQ-038 NOTE_SCROLLER_LOOP_EN with chart {01,11}: red enters every second boundary indefinitely; done stays 0.
